// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a synchronous FIFO in fixed-length bursts and
// presents the words as a valid/ready stream with an end-of-burst marker.
// A 2-entry skid buffer absorbs the FIFO's 1-cycle registered read latency,
// and reads are credit-limited so back-pressure never drops or duplicates.
// Optional feature: define RDR_TIMEOUT_EN to flush partial bursts after
// TIMEOUT_CYC idle cycles with a non-empty FIFO below BURST_LEN.
module fifo_burst_reader #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_counter,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_read_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               start;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   len_nxt;
    logic [CNT_W-1:0]   issued;
    logic               inflight;
    logic               inflight_last;
    logic               read_en;
    logic               last_read;
    logic               push;
    logic               pop;
    logic [2:0]         credit;

    // Skid buffer: entry 0 is the head presented on the stream.
    logic [1:0]         occ;
    logic [DATA_W-1:0]  data0;
    logic [DATA_W-1:0]  data1;
    logic               last0;
    logic               last1;

`ifdef RDR_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0]   timer;
    logic               tmr_cond;
    logic               timeout;

    assign tmr_cond = (state == IDLE) && !fifo_empty &&
                      (fifo_counter < CNT_W'(BURST_LEN)) &&
                      (fifo_counter != '0);
    assign timeout  = tmr_cond && (timer == TMR_W'(TIMEOUT_CYC - 1));

    // Count consecutive idle cycles holding a partial burst; clear otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (tmr_cond && !timeout) begin
            timer <= timer + TMR_W'(1);
        end else begin
            timer <= '0;
        end
    end
`endif

    // Stream side of the skid buffer.
    assign m_valid = (occ != 2'd0);
    assign m_data  = data0;
    assign m_last  = last0 && m_valid;
    assign pop     = m_valid && m_ready;
    assign push    = inflight;
    assign busy    = (state != IDLE);

    // Slots the skid will hold after this edge if no new read is issued.
    assign credit    = 3'(occ) + 3'(inflight) - 3'(pop);
    assign read_en   = (state == READ) && !fifo_empty && (issued < len) &&
                       (credit < 3'd2);
    assign last_read = read_en && (issued == (len - CNT_W'(1)));

    assign fifo_read_en = read_en;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: burst start, read phase, wait for last word accepted.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        len_nxt   = len;
        case (state)
            IDLE: begin
                if (fifo_counter >= CNT_W'(BURST_LEN)) begin
                    start     = 1'b1;
                    len_nxt   = CNT_W'(BURST_LEN);
                    state_nxt = READ;
                end
`ifdef RDR_TIMEOUT_EN
                else if (timeout) begin
                    start     = 1'b1;
                    len_nxt   = fifo_counter;
                    state_nxt = READ;
                end
`endif
            end
            READ: begin
                if (last_read) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && last0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst length latch, issued-read count and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len           <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= read_en;
            inflight_last <= last_read;
            if (start) begin
                len    <= len_nxt;
                issued <= '0;
            end else if (read_en) begin
                issued <= issued + CNT_W'(1);
            end
        end
    end

    // In-order 2-entry skid buffer with simultaneous push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= 2'd0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        data0 <= fifo_data_out;
                        last0 <= inflight_last;
                    end else begin
                        data1 <= fifo_data_out;
                        last1 <= inflight_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        data0 <= fifo_data_out;
                        last0 <= inflight_last;
                    end else begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= fifo_data_out;
                        last1 <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: behavioural FIFO model, a
// scoreboard of expected stream words, and an independent skid-occupancy
// model used to check valid timing and the read credit rule.
// Honours RDR_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned BL     = 8;
    localparam int unsigned TO     = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_counter;
    logic [DATA_W-1:0] fifo_data_out = '0;
    logic              fifo_read_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic              busy;

    fifo_burst_reader #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BL), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_counter(fifo_counter),
        .fifo_data_out(fifo_data_out), .fifo_read_en(fifo_read_en), .m_data(m_data),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO with registered read data.
    logic [DATA_W-1:0] mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    always @(posedge clk) begin
        if (fifo_read_en) begin
            fifo_data_out <= mem[rd_ptr % 256];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_counter = CNT_W'(wr_ptr - rd_ptr);

    int errors = 0;
    int checks = 0;
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W-1:0] shadow [$];
    int tb_occ  = 0;
    int tb_infl = 0;

    task automatic fifo_push(input logic [DATA_W-1:0] v);
        mem[wr_ptr % 256] = v;
        wr_ptr = wr_ptr + 1;
        shadow.push_back(v);
    endtask

    task automatic expect_burst(input int n);
        logic [DATA_W-1:0] v;
        logic lb;
        for (int i = 0; i < n; i++) begin
            v  = shadow.pop_front();
            lb = (i == n - 1);
            exp_q.push_back({lb, v});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", m_last); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", m_data); end
        checks++; if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL reset_read_en: got %b expected 0", fifo_read_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_burst();
        bit hs;
        bit done = 1'b0;
        bit busy_chk = 1'b0;
        logic [DATA_W:0] e;
        for (int v = 0; v < 10; v++) fifo_push(DATA_W'(v));
        expect_burst(BL);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk); m_ready = 1'b1; #1;
            hs = m_valid && m_ready;
            checks++;
            if (m_valid !== (tb_occ != 0)) begin errors++; $display("FAIL single_valid cyc=%0d: got %b expected %b", cyc, m_valid, tb_occ != 0); end
            if (busy_chk) begin
                busy_chk = 1'b0; checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
            end
            if (fifo_read_en) begin
                checks++;
                if (done || fifo_empty || (tb_occ + tb_infl - (hs ? 1 : 0)) >= 2) begin
                    errors++; $display("FAIL single_read_en cyc=%0d: got 1 expected 0 (occ=%0d infl=%0d)", cyc, tb_occ, tb_infl);
                end
            end
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL single_extra_word: got %0h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin errors++; $display("FAIL single_word: got last=%b data=%0h expected last=%b data=%0h", m_last, m_data, e[DATA_W], e[DATA_W-1:0]); end
                    if (exp_q.size() == 0) begin done = 1'b1; busy_chk = 1'b1; end
                end
            end
            tb_occ  = tb_occ + tb_infl - (hs ? 1 : 0);
            tb_infl = fifo_read_en ? 1 : 0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: got %0d words left expected 0", exp_q.size()); end
        checks++; if (fifo_counter !== CNT_W'(2)) begin errors++; $display("FAIL single_remaining: got %0d expected 2", fifo_counter); end
    endtask

    task automatic test_back_to_back();
        bit hs;
        logic [DATA_W:0] e;
        int run = 0;
        int nruns = 0;
        int runs [4];
        for (int v = 10; v < 26; v++) fifo_push(DATA_W'(v));
        expect_burst(BL);
        expect_burst(BL);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk); m_ready = 1'b1; #1;
            hs = m_valid && m_ready;
            checks++;
            if (m_valid !== (tb_occ != 0)) begin errors++; $display("FAIL b2b_valid cyc=%0d: got %b expected %b", cyc, m_valid, tb_occ != 0); end
            if (fifo_read_en) begin
                checks++;
                if (fifo_empty || (tb_occ + tb_infl - (hs ? 1 : 0)) >= 2) begin
                    errors++; $display("FAIL b2b_credit cyc=%0d: got 1 expected 0", cyc);
                end
                run++;
            end else if (run > 0) begin
                if (nruns < 4) runs[nruns] = run;
                nruns++; run = 0;
            end
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_word: got %0h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin errors++; $display("FAIL b2b_word: got last=%b data=%0h expected last=%b data=%0h", m_last, m_data, e[DATA_W], e[DATA_W-1:0]); end
                end
            end
            tb_occ  = tb_occ + tb_infl - (hs ? 1 : 0);
            tb_infl = fifo_read_en ? 1 : 0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d words left expected 0", exp_q.size()); end
        checks++; if (nruns != 2) begin errors++; $display("FAIL b2b_run_count: got %0d expected 2", nruns); end
        else begin
            checks++; if (runs[0] != 8) begin errors++; $display("FAIL b2b_run0: got %0d expected 8", runs[0]); end
            checks++; if (runs[1] != 8) begin errors++; $display("FAIL b2b_run1: got %0d expected 8", runs[1]); end
        end
    endtask

    task automatic test_toggle_ready();
        bit hs;
        logic [DATA_W:0] e;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic pl = 1'b0;
        logic [DATA_W-1:0] pd = '0;
        for (int v = 26; v < 32; v++) fifo_push(DATA_W'(v));
        expect_burst(BL);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk); m_ready = (cyc % 2 == 0); #1;
            hs = m_valid && m_ready;
            checks++;
            if (m_valid !== (tb_occ != 0)) begin errors++; $display("FAIL toggle_valid cyc=%0d: got %b expected %b", cyc, m_valid, tb_occ != 0); end
            if (pv && !pr) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
                    errors++; $display("FAIL toggle_stable cyc=%0d: got v=%b d=%0h l=%b expected v=1 d=%0h l=%b", cyc, m_valid, m_data, m_last, pd, pl);
                end
            end
            if (fifo_read_en) begin
                checks++;
                if (fifo_empty || (tb_occ + tb_infl - (hs ? 1 : 0)) >= 2) begin
                    errors++; $display("FAIL toggle_credit cyc=%0d: got 1 expected 0 (occ=%0d infl=%0d)", cyc, tb_occ, tb_infl);
                end
            end
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL toggle_extra_word: got %0h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin errors++; $display("FAIL toggle_word: got last=%b data=%0h expected last=%b data=%0h", m_last, m_data, e[DATA_W], e[DATA_W-1:0]); end
                end
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            tb_occ  = tb_occ + tb_infl - (hs ? 1 : 0);
            tb_infl = fifo_read_en ? 1 : 0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL toggle_drain: got %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_hold_ready();
        bit hs;
        logic [DATA_W:0] e;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic pl = 1'b0;
        logic [DATA_W-1:0] pd = '0;
        for (int v = 32; v < 40; v++) fifo_push(DATA_W'(v));
        expect_burst(BL);
        for (int cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk); m_ready = (cyc >= 15); #1;
            hs = m_valid && m_ready;
            checks++;
            if (m_valid !== (tb_occ != 0)) begin errors++; $display("FAIL hold_valid cyc=%0d: got %b expected %b", cyc, m_valid, tb_occ != 0); end
            if (pv && !pr) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
                    errors++; $display("FAIL hold_stable cyc=%0d: got v=%b d=%0h l=%b expected v=1 d=%0h l=%b", cyc, m_valid, m_data, m_last, pd, pl);
                end
            end
            if (cyc == 14) begin
                e = exp_q[0];
                checks++; if (fifo_counter !== CNT_W'(BL - 2)) begin errors++; $display("FAIL hold_reads: got level %0d expected %0d", fifo_counter, BL - 2); end
                checks++; if (m_valid !== 1'b1 || m_data !== e[DATA_W-1:0]) begin errors++; $display("FAIL hold_head: got v=%b d=%0h expected v=1 d=%0h", m_valid, m_data, e[DATA_W-1:0]); end
            end
            if (fifo_read_en) begin
                checks++;
                if (fifo_empty || (tb_occ + tb_infl - (hs ? 1 : 0)) >= 2) begin
                    errors++; $display("FAIL hold_credit cyc=%0d: got 1 expected 0 (occ=%0d infl=%0d)", cyc, tb_occ, tb_infl);
                end
            end
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL hold_extra_word: got %0h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin errors++; $display("FAIL hold_word: got last=%b data=%0h expected last=%b data=%0h", m_last, m_data, e[DATA_W], e[DATA_W-1:0]); end
                end
            end
            pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
            tb_occ  = tb_occ + tb_infl - (hs ? 1 : 0);
            tb_infl = fifo_read_en ? 1 : 0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL hold_drain: got %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        bit hs;
        logic [DATA_W:0] e;
        int first_rd = -1;
        int reads = 0;
        for (int v = 40; v < 43; v++) fifo_push(DATA_W'(v));
`ifdef RDR_TIMEOUT_EN
        expect_burst(3);
`endif
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk); m_ready = 1'b1; #1;
            hs = m_valid && m_ready;
            checks++;
            if (m_valid !== (tb_occ != 0)) begin errors++; $display("FAIL timeout_valid cyc=%0d: got %b expected %b", cyc, m_valid, tb_occ != 0); end
            if (fifo_read_en) begin
                reads++;
                if (first_rd < 0) first_rd = cyc;
                checks++;
                if (fifo_empty || (tb_occ + tb_infl - (hs ? 1 : 0)) >= 2) begin
                    errors++; $display("FAIL timeout_credit cyc=%0d: got 1 expected 0", cyc);
                end
            end
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL timeout_extra_word: got %0h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin errors++; $display("FAIL timeout_word: got last=%b data=%0h expected last=%b data=%0h", m_last, m_data, e[DATA_W], e[DATA_W-1:0]); end
                end
            end
            tb_occ  = tb_occ + tb_infl - (hs ? 1 : 0);
            tb_infl = fifo_read_en ? 1 : 0;
        end
`ifdef RDR_TIMEOUT_EN
        checks++; if (first_rd != TO) begin errors++; $display("FAIL timeout_start: got cycle %0d expected %0d", first_rd, TO); end
        checks++; if (reads != 3) begin errors++; $display("FAIL timeout_reads: got %0d expected 3", reads); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_drain: got %0d words left expected 0", exp_q.size()); end
`else
        checks++; if (reads != 0) begin errors++; $display("FAIL timeout_no_read: got %0d reads (first at %0d) expected 0", reads, first_rd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        checks++; if (fifo_counter !== CNT_W'(3)) begin errors++; $display("FAIL timeout_level: got %0d expected 3", fifo_counter); end
`endif
    endtask

    task automatic test_mid_burst_reset();
        bit hs;
        logic [DATA_W:0] e;
        int accepted = 0;
        int reads = 0;
        for (int v = 43; v < 59; v++) fifo_push(DATA_W'(v));
        expect_burst(BL);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (accepted == 4) break;
            m_ready = 1'b1; #1;
            hs = m_valid && m_ready;
            if (fifo_read_en) reads++;
            if (hs) begin
                checks++;
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e) begin errors++; $display("FAIL rstb_word: got last=%b data=%0h expected last=%b data=%0h", m_last, m_data, e[DATA_W], e[DATA_W-1:0]); end
                accepted++;
            end
        end
        checks++; if (accepted != 4) begin errors++; $display("FAIL rstb_progress: got %0d words expected 4", accepted); end
        rst = 1'b1; #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstb_valid: got %b expected 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rstb_last: got %b expected 0", m_last); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL rstb_data: got %0h expected 0", m_data); end
        checks++; if (fifo_read_en !== 1'b0) begin errors++; $display("FAIL rstb_read_en: got %b expected 0", fifo_read_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstb_busy: got %b expected 0", busy); end
        // Words read but not accepted are lost; unread ones stay in the FIFO.
        for (int i = 0; i < reads - accepted; i++) e = exp_q.pop_front();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_back();
            shadow.push_front(e[DATA_W-1:0]);
        end
        tb_occ = 0; tb_infl = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        checks++; if (fifo_counter !== CNT_W'(shadow.size())) begin errors++; $display("FAIL rstb_level: got %0d expected %0d", fifo_counter, shadow.size()); end
        expect_burst(BL);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk); m_ready = 1'b1; #1;
            hs = m_valid && m_ready;
            checks++;
            if (m_valid !== (tb_occ != 0)) begin errors++; $display("FAIL rsta_valid cyc=%0d: got %b expected %b", cyc, m_valid, tb_occ != 0); end
            if (fifo_read_en) begin
                checks++;
                if (fifo_empty || (tb_occ + tb_infl - (hs ? 1 : 0)) >= 2) begin
                    errors++; $display("FAIL rsta_credit cyc=%0d: got 1 expected 0", cyc);
                end
            end
            if (hs) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rsta_extra_word: got %0h expected none", m_data); end
                else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin errors++; $display("FAIL rsta_word: got last=%b data=%0h expected last=%b data=%0h", m_last, m_data, e[DATA_W], e[DATA_W-1:0]); end
                end
            end
            tb_occ  = tb_occ + tb_infl - (hs ? 1 : 0);
            tb_infl = fifo_read_en ? 1 : 0;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rsta_drain: got %0d words left expected 0", exp_q.size()); end
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_toggle_ready();
        test_hold_ready();
        test_timeout();
        test_mid_burst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
